// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_pkg                                                          |
// | Desc    : Shared run-control state encoding and fault codes.               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] FLT_NONE = 2'b00;
    localparam logic [1:0] FLT_OVF  = 2'b01;
    localparam logic [1:0] FLT_UNF  = 2'b10;
    localparam logic [1:0] FLT_TMO  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/ret_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ret_stack                                                        |
// | Desc    : Return-address LIFO; push ignored when full, pop when empty.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ret_stack #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            init,
    input  logic            clear,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic            full,
    output logic            empty
);

    localparam int            c_aw   = $clog2(STACK_DEPTH);
    localparam logic [c_aw:0] c_full = (c_aw + 1)'(STACK_DEPTH);
    localparam logic [c_aw:0] c_one  = (c_aw + 1)'(1);

    logic [c_aw:0]     r_cnt;
    logic [PC_W-1:0]   r_mem [STACK_DEPTH];
    logic [c_aw-1:0]   w_top_idx;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_cnt == c_full);
    assign empty     = (r_cnt == '0);
    assign w_do_push = push && !full && !clear;
    assign w_do_pop  = pop && !empty && !clear;
    assign w_top_idx = r_cnt[c_aw-1:0] - c_aw'(1);
    assign top       = r_mem[w_top_idx];

    always_ff @(posedge CLK or posedge init) begin
        if (init) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (w_do_push) begin
            r_cnt <= r_cnt + c_one;
        end else if (w_do_pop) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    // Storage needs no reset: an entry is only ever read below the fill pointer.
    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_cnt[c_aw-1:0]] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fetch_sequencer                                                  |
// | Desc    : Run-control FSM driving the PC: start, stall, call/ret, halt.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module fetch_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4,
    parameter int STALL_LIMIT = 255
) (
    input  logic            CLK,
    input  logic            init,
    input  logic            start,
    input  logic [PC_W-1:0] pc,
    input  logic            pc_halt,
    input  logic            dec_jump,
    input  logic            dec_branch,
    input  logic            cond_flag,
    input  logic            dec_call,
    input  logic            dec_ret,
    input  logic [PC_W-1:0] dec_target,
    input  logic            mem_busy,
    output logic            pc_init,
    output logic            pc_jump_en,
    output logic            pc_branch_en,
    output logic [PC_W-1:0] pc_dest,
    output logic            commit,
    output logic            running,
    output logic            done,
    output logic            fault,
    output logic [1:0]      fault_code
);

    localparam int              c_cw    = $clog2(STALL_LIMIT + 1);
    localparam logic [c_cw-1:0] c_limit = c_cw'(STALL_LIMIT);

    state_t          r_state;
    logic [c_cw-1:0] r_stall_cnt;
    logic            r_fault;
    logic [1:0]      r_fault_code;

    state_t          w_next;
    logic [c_cw-1:0] w_cnt_nxt;
    logic            w_cnt_clr, w_cnt_inc;
    logic            w_set_fault, w_clr_fault;
    logic [1:0]      w_new_code;
    logic            w_push, w_pop, w_stk_clear;
    logic [PC_W-1:0] w_stk_top;
    logic            w_stk_full, w_stk_empty;

    ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .CLK   (CLK),
        .init  (init),
        .clear (w_stk_clear),
        .push  (w_push),
        .pop   (w_pop),
        .din   (pc + PC_W'(1)),
        .top   (w_stk_top),
        .full  (w_stk_full),
        .empty (w_stk_empty)
    );

    assign w_cnt_nxt  = (r_stall_cnt == '1) ? r_stall_cnt : r_stall_cnt + c_cw'(1);
    assign running    = (r_state == RUN) || (r_state == STALL);
    assign done       = (r_state == DONE);
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

    always_comb begin
        pc_init      = 1'b0;
        pc_jump_en   = 1'b0;
        pc_branch_en = 1'b0;
        pc_dest      = '0;
        commit       = 1'b0;
        w_next       = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_set_fault  = 1'b0;
        w_clr_fault  = 1'b0;
        w_new_code   = FLT_NONE;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_stk_clear  = 1'b0;
        unique case (r_state)
            IDLE: begin
                pc_init = 1'b1;
                if (start) w_next = RUN;
            end
            RUN, STALL: begin
                if (pc_halt) begin
                    pc_jump_en = 1'b1;
                    pc_dest    = pc;
                    w_next     = DONE;
                end else if (mem_busy) begin
                    pc_jump_en = 1'b1;
                    pc_dest    = pc;
                    if (r_state == RUN) begin
                        w_cnt_clr = 1'b1;
                        w_next    = STALL;
                    end else begin
                        w_cnt_inc = 1'b1;
                        if (w_cnt_nxt == c_limit) begin
                            w_set_fault = 1'b1;
                            w_new_code  = FLT_TMO;
                            w_next      = DONE;
                        end
                    end
                end else begin
                    commit = 1'b1;
                    w_next = RUN;
                    // A faulting call/ret does not retire: PC frozen, no writes.
                    if (dec_ret) begin
                        pc_jump_en = 1'b1;
                        if (w_stk_empty) begin
                            commit      = 1'b0;
                            pc_dest     = pc;
                            w_set_fault = 1'b1;
                            w_new_code  = FLT_UNF;
                            w_next      = DONE;
                        end else begin
                            w_pop   = 1'b1;
                            pc_dest = w_stk_top;
                        end
                    end else if (dec_call) begin
                        pc_jump_en = 1'b1;
                        if (w_stk_full) begin
                            commit      = 1'b0;
                            pc_dest     = pc;
                            w_set_fault = 1'b1;
                            w_new_code  = FLT_OVF;
                            w_next      = DONE;
                        end else begin
                            w_push  = 1'b1;
                            pc_dest = dec_target;
                        end
                    end else if (dec_jump) begin
                        pc_jump_en = 1'b1;
                        pc_dest    = dec_target;
                    end else if (dec_branch && cond_flag) begin
                        pc_branch_en = 1'b1;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    pc_init     = 1'b1;
                    w_clr_fault = 1'b1;
                    w_stk_clear = 1'b1;
                    w_next      = RUN;
                end else begin
                    pc_jump_en = 1'b1;
                    pc_dest    = pc;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge init) begin
        if (init) begin
            r_state      <= IDLE;
            r_stall_cnt  <= '0;
            r_fault      <= 1'b0;
            r_fault_code <= FLT_NONE;
        end else begin
            r_state <= w_next;
            if (w_cnt_clr) begin
                r_stall_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_stall_cnt <= w_cnt_nxt;
            end
            if (w_clr_fault) begin
                r_fault      <= 1'b0;
                r_fault_code <= FLT_NONE;
            end else if (w_set_fault) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_new_code;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fetch_sequencer                                               |
// | Desc    : Self-checking bench with a behavioural PC register model.        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_fetch_sequencer;

    localparam int PC_W = 10;

    logic            CLK = 1'b0;
    logic            init = 1'b1;
    logic            start = 1'b0;
    logic [PC_W-1:0] pc = '0;
    logic            pc_halt = 1'b0;
    logic            dec_jump = 1'b0, dec_branch = 1'b0, cond_flag = 1'b0;
    logic            dec_call = 1'b0, dec_ret = 1'b0, mem_busy = 1'b0;
    logic [PC_W-1:0] dec_target = '0;
    logic            pc_init, pc_jump_en, pc_branch_en, commit, running, done, fault;
    logic [PC_W-1:0] pc_dest;
    logic [1:0]      fault_code;

    int              n_cmp = 0;
    int              n_bad = 0;
    logic [PC_W-1:0] exp_q [$];

    always #5 CLK = ~CLK;

    fetch_sequencer #(.PC_W(PC_W), .STACK_DEPTH(4), .STALL_LIMIT(255)) dut (
        .CLK(CLK), .init(init), .start(start), .pc(pc), .pc_halt(pc_halt),
        .dec_jump(dec_jump), .dec_branch(dec_branch), .cond_flag(cond_flag),
        .dec_call(dec_call), .dec_ret(dec_ret), .dec_target(dec_target),
        .mem_busy(mem_busy), .pc_init(pc_init), .pc_jump_en(pc_jump_en),
        .pc_branch_en(pc_branch_en), .pc_dest(pc_dest), .commit(commit),
        .running(running), .done(done), .fault(fault), .fault_code(fault_code)
    );

    // PC register the sequencer steers
    always @(posedge CLK) begin
        if (pc_init)           pc <= '0;
        else if (pc_jump_en)   pc <= pc_dest;
        else if (pc_branch_en) pc <= pc + 10'd2;
        else                   pc <= pc + 10'd1;
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic clr_ctl();
        start = 0; pc_halt = 0; dec_jump = 0; dec_branch = 0; cond_flag = 0;
        dec_call = 0; dec_ret = 0; mem_busy = 0; dec_target = '0;
    endtask

    task automatic start_prog();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic run_to(input logic [PC_W-1:0] t);
        for (int i = 0; i < 300; i++) begin
            if (pc == t) return;
            cyc();
        end
        n_cmp++; n_bad++;
        $display("FAIL run_to: pc=%0d required %0d", pc, t);
    endtask

    task automatic test_reset();
        clr_ctl();
        init = 1'b1;
        repeat (3) cyc();
        smp();
        n_cmp++;
        if ({pc_init, running, done, commit, pc_jump_en, pc_branch_en, fault} !== 7'b1000000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b required 1000000",
                     {pc_init, running, done, commit, pc_jump_en, pc_branch_en, fault});
        end
        n_cmp++;
        if (pc_dest !== 10'd0) begin n_bad++; $display("FAIL reset_dest: got %0d required 0", pc_dest); end
        n_cmp++;
        if (fault_code !== 2'b00) begin n_bad++; $display("FAIL reset_code: got %b required 00", fault_code); end
        cyc();
        init = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        logic [PC_W-1:0] e;
        start = 1'b1;
        smp();
        n_cmp++;
        if (pc_init !== 1'b1 || running !== 1'b0) begin
            n_bad++; $display("FAIL start_init: pc_init=%b running=%b required 1/0", pc_init, running);
        end
        cyc();
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(PC_W'(i));
            smp();
            e = exp_q.pop_front();
            n_cmp++;
            if (pc !== e || commit !== 1'b1) begin
                n_bad++; $display("FAIL run_commit: pc=%0d commit=%b required %0d/1", pc, commit, e);
            end
            cyc();
        end
        start = 1'b1;
        smp();
        n_cmp++;
        if (pc_init !== 1'b0 || running !== 1'b1) begin
            n_bad++; $display("FAIL start_ignored: pc_init=%b running=%b required 0/1", pc_init, running);
        end
        cyc();
        start = 1'b0;
        pc_halt = 1'b1;
        smp();
        n_cmp++;
        if (commit !== 1'b0 || pc_jump_en !== 1'b1 || pc_dest !== 10'd65) begin
            n_bad++; $display("FAIL halt_hold: commit=%b jump=%b dest=%0d required 0/1/65", commit, pc_jump_en, pc_dest);
        end
        cyc();
        pc_halt = 1'b0;
        smp();
        n_cmp++;
        if (done !== 1'b1 || fault !== 1'b0 || running !== 1'b0 || pc !== 10'd65) begin
            n_bad++; $display("FAIL halt_done: done=%b fault=%b running=%b pc=%0d required 1/0/0/65", done, fault, running, pc);
        end
        cyc();
    endtask

    task automatic test_call_ret();
        start_prog();
        run_to(10'd5);
        dec_call = 1'b1; dec_target = 10'd20;
        exp_q.push_back(10'd20);
        smp();
        n_cmp++;
        if (pc_jump_en !== 1'b1 || pc_dest !== exp_q.pop_front() || commit !== 1'b1) begin
            n_bad++; $display("FAIL call_dest: jump=%b dest=%0d commit=%b required 1/20/1", pc_jump_en, pc_dest, commit);
        end
        cyc();
        clr_ctl();
        run_to(10'd22);
        dec_ret = 1'b1;
        exp_q.push_back(10'd6);
        smp();
        n_cmp++;
        if (pc_jump_en !== 1'b1 || pc_dest !== exp_q.pop_front()) begin
            n_bad++; $display("FAIL ret_dest: jump=%b dest=%0d required 1/6", pc_jump_en, pc_dest);
        end
        cyc();
        dec_ret = 1'b0;
        smp();
        n_cmp++;
        if (pc !== 10'd6) begin n_bad++; $display("FAIL ret_pc: got %0d required 6", pc); end
        cyc();
        dec_ret = 1'b1;
        cyc();
        dec_ret = 1'b0;
        smp();
        n_cmp++;
        if (fault_code !== 2'b10 || done !== 1'b1) begin
            n_bad++; $display("FAIL stack_empty_after: code=%b done=%b required 10/1", fault_code, done);
        end
        cyc();
    endtask

    task automatic do_calls(input bit check);
        for (int k = 0; k < 4; k++) begin
            dec_call   = 1'b1;
            dec_target = PC_W'(100 * (k + 1));
            exp_q.push_back((k == 0) ? 10'd3 : PC_W'(100 * k + 1));
            smp();
            if (check) begin
                n_cmp++;
                if (pc_jump_en !== 1'b1 || pc_dest !== PC_W'(100 * (k + 1))) begin
                    n_bad++; $display("FAIL nest_call%0d: dest=%0d required %0d", k, pc_dest, 100 * (k + 1));
                end
            end
            cyc();
        end
        clr_ctl();
    endtask

    task automatic test_stack_lifo();
        logic [PC_W-1:0] e;
        start_prog();
        run_to(10'd2);
        do_calls(1'b1);
        dec_ret = 1'b1;
        for (int k = 0; k < 4; k++) begin
            smp();
            e = exp_q.pop_back();
            n_cmp++;
            if (pc_jump_en !== 1'b1 || pc_dest !== e) begin
                n_bad++; $display("FAIL lifo_ret%0d: dest=%0d required %0d", k, pc_dest, e);
            end
            cyc();
        end
        dec_ret = 1'b0;
        pc_halt = 1'b1;
        cyc();
        pc_halt = 1'b0;
    endtask

    task automatic test_overflow();
        start_prog();
        run_to(10'd2);
        do_calls(1'b0);
        exp_q.delete();
        dec_call = 1'b1; dec_target = 10'd500;
        smp();
        n_cmp++;
        if (pc_jump_en !== 1'b1 || pc_dest !== 10'd400) begin
            n_bad++; $display("FAIL ovf_hold: jump=%b dest=%0d required 1/400", pc_jump_en, pc_dest);
        end
        cyc();
        clr_ctl();
        smp();
        n_cmp++;
        if (fault_code !== 2'b01 || done !== 1'b1 || fault !== 1'b1) begin
            n_bad++; $display("FAIL ovf_fault: code=%b done=%b fault=%b required 01/1/1", fault_code, done, fault);
        end
        repeat (3) cyc();
        smp();
        n_cmp++;
        if (pc !== 10'd400) begin n_bad++; $display("FAIL ovf_frozen: pc=%0d required 400", pc); end
        cyc();
    endtask

    task automatic test_underflow();
        start_prog();
        run_to(10'd3);
        dec_ret = 1'b1;
        smp();
        n_cmp++;
        if (pc_jump_en !== 1'b1 || pc_dest !== 10'd3) begin
            n_bad++; $display("FAIL unf_hold: jump=%b dest=%0d required 1/3", pc_jump_en, pc_dest);
        end
        cyc();
        dec_ret = 1'b0;
        smp();
        n_cmp++;
        if (fault_code !== 2'b10 || done !== 1'b1 || fault !== 1'b1) begin
            n_bad++; $display("FAIL unf_fault: code=%b done=%b fault=%b required 10/1/1", fault_code, done, fault);
        end
        repeat (2) cyc();
        smp();
        n_cmp++;
        if (pc !== 10'd3) begin n_bad++; $display("FAIL unf_frozen: pc=%0d required 3", pc); end
        cyc();
    endtask

    task automatic test_stall();
        int n;
        start_prog();
        run_to(10'd7);
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            n_cmp++;
            if (commit !== 1'b0 || pc !== 10'd7) begin
                n_bad++; $display("FAIL stall_hold%0d: commit=%b pc=%0d required 0/7", i, commit, pc);
            end
            cyc();
        end
        mem_busy = 1'b0;
        smp();
        n_cmp++;
        if (commit !== 1'b1) begin n_bad++; $display("FAIL stall_release: commit=%b required 1", commit); end
        cyc();
        smp();
        n_cmp++;
        if (pc !== 10'd8 || running !== 1'b1) begin
            n_bad++; $display("FAIL stall_advance: pc=%0d running=%b required 8/1", pc, running);
        end
        cyc();
        mem_busy = 1'b1;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            cyc();
            if (done) begin n = i; break; end
        end
        n_cmp++;
        if (n != 256) begin n_bad++; $display("FAIL timeout_cycles: got %0d required 256", n); end
        smp();
        n_cmp++;
        if (fault_code !== 2'b11 || fault !== 1'b1 || pc !== 10'd9) begin
            n_bad++; $display("FAIL timeout_fault: code=%b fault=%b pc=%0d required 11/1/9", fault_code, fault, pc);
        end
        mem_busy = 1'b0;
        cyc();
    endtask

    task automatic test_branch_jump();
        start_prog();
        run_to(10'd10);
        dec_branch = 1'b1; cond_flag = 1'b1;
        smp();
        n_cmp++;
        if (pc_branch_en !== 1'b1 || pc_jump_en !== 1'b0 || pc_dest !== 10'd0) begin
            n_bad++; $display("FAIL branch_taken: br=%b jump=%b dest=%0d required 1/0/0", pc_branch_en, pc_jump_en, pc_dest);
        end
        cyc();
        cond_flag = 1'b0;
        smp();
        n_cmp++;
        if (pc !== 10'd12 || pc_branch_en !== 1'b0) begin
            n_bad++; $display("FAIL branch_skip: pc=%0d br=%b required 12/0", pc, pc_branch_en);
        end
        cyc();
        clr_ctl();
        smp();
        n_cmp++;
        if (pc !== 10'd13) begin n_bad++; $display("FAIL branch_fall: pc=%0d required 13", pc); end
        cyc();
        dec_jump = 1'b1; dec_target = 10'd50; dec_branch = 1'b1; cond_flag = 1'b1;
        smp();
        n_cmp++;
        if (pc_jump_en !== 1'b1 || pc_dest !== 10'd50 || pc_branch_en !== 1'b0) begin
            n_bad++; $display("FAIL jump_prio: jump=%b dest=%0d br=%b required 1/50/0", pc_jump_en, pc_dest, pc_branch_en);
        end
        cyc();
        clr_ctl();
        smp();
        n_cmp++;
        if (pc !== 10'd50) begin n_bad++; $display("FAIL jump_pc: pc=%0d required 50", pc); end
        cyc();
    endtask

    task automatic test_init_midstall();
        mem_busy = 1'b1;
        repeat (2) cyc();
        smp();
        n_cmp++;
        if (running !== 1'b1 || commit !== 1'b0) begin
            n_bad++; $display("FAIL midstall_state: running=%b commit=%b required 1/0", running, commit);
        end
        #2 init = 1'b1;
        #1;
        n_cmp++;
        if ({pc_init, running, done, commit, pc_jump_en, pc_branch_en, fault} !== 7'b1000000
            || pc_dest !== 10'd0 || fault_code !== 2'b00) begin
            n_bad++;
            $display("FAIL async_init: flags=%b dest=%0d code=%b required 1000000/0/00",
                     {pc_init, running, done, commit, pc_jump_en, pc_branch_en, fault}, pc_dest, fault_code);
        end
        clr_ctl();
        cyc();
        init = 1'b0;
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_call_ret();
        test_stack_lifo();
        test_overflow();
        test_underflow();
        test_stall();
        test_branch_jump();
        test_init_midstall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
